voice_allocator: RTL and testbench

- Polyphony scheduler. Shares a small pool of NUM_VOICES programmable oscillator voices among NUM_KEYS keypad keys.
- A round-robin key scanner detects press and release events, one key per cycle. It assigns each press to a free voice or steals the oldest voice, and frees the voice on release.
- A sustain input defers all releases.
- Outputs drive the per-voice enable and key index of the oscillator/wave_shaper voices that feed the mixer.

---
 rtl/voice_allocator.sv | 190 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphony scheduler: shares NUM_VOICES oscillator voices among NUM_KEYS keys.
// A round-robin scanner looks at one key per cycle. A press takes a voice:
// retrigger of the voice already playing that key, else the lowest free voice,
// else the oldest sustained voice, else the oldest voice. A release frees the
// voice, or marks it sustained while the sustain pedal is down. The falling
// edge of sustain drops every sustained voice and pauses the scan for a cycle.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   keys         key levels, synchronous to clk, 1 = held
//   sustain      sustain pedal level, synchronous to clk
//   voice_en     per-voice sounding flag
//   voice_key    per-voice key index, voice v in [v*KEY_W +: KEY_W]
//   note_on      per-voice one-cycle pulse on assign/retrigger
//   steal        one-cycle pulse when an assignment displaced an active voice
//   active_count number of sounding voices

module voice_allocator #(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 4,
    parameter int AGE_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         keys,
    input  logic                        sustain,
    output logic [NUM_VOICES-1:0]       voice_en,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic [NUM_VOICES-1:0]       note_on,
    output logic                        steal,
    output logic [KEY_W-1:0]            active_count
);

    logic [KEY_W-1:0]      idx_q, idx_d;
    logic [NUM_KEYS-1:0]   key_state_q, key_state_d;
    logic                  sustain_q, sustain_d;
    logic [NUM_VOICES-1:0] voice_en_q, voice_en_d;
    logic [KEY_W-1:0]      voice_key_q [NUM_VOICES];
    logic [KEY_W-1:0]      voice_key_d [NUM_VOICES];
    logic [AGE_W-1:0]      age_q [NUM_VOICES];
    logic [AGE_W-1:0]      age_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] sus_q, sus_d;
    logic [NUM_VOICES-1:0] note_on_q, note_on_d;
    logic                  steal_q, steal_d;
    logic [KEY_W-1:0]      active_count_q, active_count_d;

    logic                  match_found, free_found, sus_found;
    int                    match_v, free_v, sus_v, old_v, target_v;
    logic [AGE_W-1:0]      sus_age, old_age;

    always_comb begin
        idx_d          = idx_q;
        key_state_d    = key_state_q;
        sustain_d      = sustain;
        voice_en_d     = voice_en_q;
        voice_key_d    = voice_key_q;
        age_d          = age_q;
        sus_d          = sus_q;
        note_on_d      = '0;
        steal_d        = 1'b0;
        active_count_d = '0;

        match_found = 1'b0;
        match_v     = 0;
        free_found  = 1'b0;
        free_v      = 0;
        sus_found   = 1'b0;
        sus_v       = 0;
        sus_age     = '0;
        old_v       = 0;
        old_age     = '0;
        target_v    = 0;

        // Candidate search; strict '>' keeps ties on the lowest index.
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_en_q[v] && (voice_key_q[v] == idx_q) && !match_found) begin
                match_found = 1'b1;
                match_v     = v;
            end
            if (!voice_en_q[v] && !free_found) begin
                free_found = 1'b1;
                free_v     = v;
            end
            if (voice_en_q[v] && sus_q[v] && (!sus_found || (age_q[v] > sus_age))) begin
                sus_found = 1'b1;
                sus_v     = v;
                sus_age   = age_q[v];
            end
            if ((v == 0) || (age_q[v] > old_age)) begin
                old_v   = v;
                old_age = age_q[v];
            end
        end

        if (sustain_q && !sustain) begin
            // Pedal lifted: drop all sustained voices; the scan pauses.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (sus_q[v]) begin
                    voice_en_d[v] = 1'b0;
                    sus_d[v]      = 1'b0;
                end
            end
        end else begin
            idx_d = (idx_q == KEY_W'(NUM_KEYS - 1)) ? '0 : idx_q + KEY_W'(1);

            if (keys[idx_q] && !key_state_q[idx_q]) begin
                key_state_d[idx_q] = 1'b1;
                if (match_found) begin
                    target_v = match_v;
                end else if (free_found) begin
                    target_v = free_v;
                end else if (sus_found) begin
                    target_v = sus_v;
                    steal_d  = 1'b1;
                end else begin
                    target_v = old_v;
                    steal_d  = 1'b1;
                end
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (v == target_v) begin
                        voice_en_d[v]  = 1'b1;
                        voice_key_d[v] = idx_q;
                        sus_d[v]       = 1'b0;
                        age_d[v]       = '0;
                        note_on_d[v]   = 1'b1;
                    end else if (voice_en_q[v] && (age_q[v] != '1)) begin
                        age_d[v] = age_q[v] + AGE_W'(1);
                    end
                end
            end else if (!keys[idx_q] && key_state_q[idx_q]) begin
                key_state_d[idx_q] = 1'b0;
                // A stolen key has no matching voice and changes nothing.
                if (match_found) begin
                    if (sustain) begin
                        sus_d[match_v] = 1'b1;
                    end else begin
                        voice_en_d[match_v] = 1'b0;
                    end
                end
            end
        end

        for (int v = 0; v < NUM_VOICES; v++) begin
            active_count_d = active_count_d + KEY_W'(voice_en_d[v]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q          <= '0;
            key_state_q    <= '0;
            sustain_q      <= 1'b0;
            voice_en_q     <= '0;
            sus_q          <= '0;
            note_on_q      <= '0;
            steal_q        <= 1'b0;
            active_count_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_key_q[v] <= '0;
                age_q[v]       <= '0;
            end
        end else begin
            idx_q          <= idx_d;
            key_state_q    <= key_state_d;
            sustain_q      <= sustain_d;
            voice_en_q     <= voice_en_d;
            sus_q          <= sus_d;
            note_on_q      <= note_on_d;
            steal_q        <= steal_d;
            active_count_q <= active_count_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_key_q[v] <= voice_key_d[v];
                age_q[v]       <= age_d[v];
            end
        end
    end

    assign voice_en     = voice_en_q;
    assign note_on      = note_on_q;
    assign steal        = steal_q;
    assign active_count = active_count_q;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_key_out
        assign voice_key[g*KEY_W +: KEY_W] = voice_key_q[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator. The bench tracks the scan index itself
// (advance each edge, hold on a sustain falling edge) so it can predict the
// exact cycle on which a key is looked at.

module tb_voice_allocator;

    logic        clk;
    logic        rst;
    logic [12:0] keys;
    logic        sustain;
    logic [3:0]  voice_en;
    logic [15:0] voice_key;
    logic [3:0]  note_on;
    logic        steal;
    logic [3:0]  active_count;

    int n_checks = 0;
    int n_fail   = 0;
    int scan     = 0;
    bit prev_sus = 1'b0;
    logic [3:0] seen;

    voice_allocator #(
        .NUM_KEYS  (13),
        .NUM_VOICES(4),
        .KEY_W     (4),
        .AGE_W     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .keys        (keys),
        .sustain     (sustain),
        .voice_en    (voice_en),
        .voice_key   (voice_key),
        .note_on     (note_on),
        .steal       (steal),
        .active_count(active_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: from a falling edge, through the rising edge, to the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            scan     = 0;
            prev_sus = 1'b0;
        end else begin
            if (!(prev_sus && !sustain)) scan = (scan + 1) % 13;
            prev_sus = sustain;
        end
        @(negedge clk);
    endtask

    // Tick until key k has just been processed (no sustain drop in between).
    task automatic run_to(input int k);
        int n;
        n = ((k - scan + 13) % 13) + 1;
        repeat (n) tick();
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        keys    = '0;
        sustain = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        scan     = 0;
        prev_sus = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_en"},    32'(voice_en),     32'h0);
        chk({tag, "_key"},   32'(voice_key),    32'h0);
        chk({tag, "_non"},   32'(note_on),      32'h0);
        chk({tag, "_steal"}, 32'(steal),        32'h0);
        chk({tag, "_cnt"},   32'(active_count), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        keys    = '0;
        sustain = 1'b0;
        @(negedge clk);
        tick();
        chk_all_zero("reset");
        rst      = 1'b0;
        scan     = 0;
        prev_sus = 1'b0;

        // Single key 3
        keys[3] = 1'b1;
        repeat (3) tick();
        chk("k3_early_en", 32'(voice_en), 32'h0);
        tick();
        chk("k3_en",    32'(voice_en),     32'h1);
        chk("k3_key",   32'(voice_key),    32'h0003);
        chk("k3_non",   32'(note_on),      32'h1);
        chk("k3_steal", 32'(steal),        32'h0);
        chk("k3_cnt",   32'(active_count), 32'h1);
        tick();
        chk("k3_non_pulse", 32'(note_on), 32'h0);
        keys[3] = 1'b0;
        run_to(3);
        chk("k3_rel_en",  32'(voice_en),     32'h0);
        chk("k3_rel_cnt", 32'(active_count), 32'h0);

        // Keys 0-4 together, key 4 steals voice 0
        apply_reset();
        keys[4:0] = 5'h1F;
        tick();
        chk("k5_a_en",  32'(voice_en), 32'h1);
        chk("k5_a_non", 32'(note_on),  32'h1);
        tick();
        chk("k5_b_en",  32'(voice_en), 32'h3);
        chk("k5_b_non", 32'(note_on),  32'h2);
        tick();
        chk("k5_c_en",  32'(voice_en), 32'h7);
        chk("k5_c_non", 32'(note_on),  32'h4);
        tick();
        chk("k5_d_en",  32'(voice_en),     32'hF);
        chk("k5_d_non", 32'(note_on),      32'h8);
        chk("k5_d_key", 32'(voice_key),    32'h3210);
        chk("k5_d_cnt", 32'(active_count), 32'h4);
        tick();
        chk("k5_steal",     32'(steal),        32'h1);
        chk("k5_steal_non", 32'(note_on),      32'h1);
        chk("k5_steal_key", 32'(voice_key),    32'h3214);
        chk("k5_steal_en",  32'(voice_en),     32'hF);
        chk("k5_steal_cnt", 32'(active_count), 32'h4);
        tick();
        chk("k5_steal_pulse", 32'(steal),   32'h0);
        chk("k5_non_pulse",   32'(note_on), 32'h0);
        keys[0] = 1'b0;
        run_to(0);
        chk("k0_rel_en",    32'(voice_en),  32'hF);
        chk("k0_rel_key",   32'(voice_key), 32'h3214);
        chk("k0_rel_non",   32'(note_on),   32'h0);
        chk("k0_rel_steal", 32'(steal),     32'h0);

        // Asynchronous reset mid-operation, between clock edges
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        keys    = '0;
        sustain = 1'b0;
        @(negedge clk);
        tick();
        rst      = 1'b0;
        scan     = 0;
        prev_sus = 1'b0;
        keys[2]  = 1'b1;
        tick();
        tick();
        chk("rst_idx_early", 32'(note_on), 32'h0);
        tick();
        chk("rst_idx_non", 32'(note_on),   32'h1);
        chk("rst_idx_key", 32'(voice_key), 32'h0002);
        keys[2] = 1'b0;
        run_to(2);
        chk("rst_idx_rel", 32'(voice_en), 32'h0);

        // Sustain hold, retrigger, pedal release with scan pause
        apply_reset();
        sustain = 1'b1;
        keys[5] = 1'b1;
        run_to(5);
        chk("sus_on_en",  32'(voice_en),  32'h1);
        chk("sus_on_key", 32'(voice_key), 32'h0005);
        keys[5] = 1'b0;
        run_to(5);
        chk("sus_hold_en",  32'(voice_en),     32'h1);
        chk("sus_hold_cnt", 32'(active_count), 32'h1);
        keys[5] = 1'b1;
        run_to(5);
        chk("retrig_non",   32'(note_on),      32'h1);
        chk("retrig_cnt",   32'(active_count), 32'h1);
        chk("retrig_steal", 32'(steal),        32'h0);
        keys[5] = 1'b0;
        run_to(5);
        chk("sus_hold2_en", 32'(voice_en), 32'h1);
        sustain = 1'b0;
        tick();
        chk("sus_fall_en",  32'(voice_en),     32'h0);
        chk("sus_fall_cnt", 32'(active_count), 32'h0);
        keys[6] = 1'b1;
        tick();
        chk("sus_fall_idx_non", 32'(note_on),   32'h1);
        chk("sus_fall_idx_key", 32'(voice_key), 32'h0006);
        keys[6] = 1'b0;
        run_to(6);
        chk("sus_k6_rel", 32'(voice_en), 32'h0);

        // Steal prefers the oldest sustained voice over older held voices
        apply_reset();
        sustain = 1'b1;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        tick();
        tick();
        keys[4] = 1'b1;
        keys[5] = 1'b1;
        run_to(5);
        chk("ss_fill_key", 32'(voice_key), 32'h5410);
        chk("ss_fill_en",  32'(voice_en),  32'hF);
        keys[4] = 1'b0;
        keys[5] = 1'b0;
        run_to(5);
        chk("ss_sus_en", 32'(voice_en), 32'hF);
        keys[4] = 1'b1;
        run_to(4);
        chk("ss_retrig_non",   32'(note_on), 32'h4);
        chk("ss_retrig_steal", 32'(steal),   32'h0);
        keys[4] = 1'b0;
        run_to(4);
        keys[7] = 1'b1;
        run_to(7);
        chk("ss_steal",     32'(steal),        32'h1);
        chk("ss_steal_non", 32'(note_on),      32'h8);
        chk("ss_steal_key", 32'(voice_key),    32'h7410);
        chk("ss_steal_en",  32'(voice_en),     32'hF);
        chk("ss_steal_cnt", 32'(active_count), 32'h4);

        // Short pulse on key 6 between scan visits is never seen
        apply_reset();
        keys[6] = 1'b1;
        tick();
        tick();
        keys[6] = 1'b0;
        seen = '0;
        repeat (13) begin
            tick();
            seen = seen | note_on | voice_en;
        end
        chk("glitch_none", 32'(seen), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
